// File: rtl/frame_slot_mgr.sv
// frame_slot_mgr: owns FRAMES_AMOUNT frame slots and hands their base addresses to one writer and one reader.
// Define FRAME_SLOT_MGR_STATS_EN to build the committed/new-read frame counters.
module frame_slot_mgr #(
    parameter int unsigned START_ADDR       = 0,
    parameter int unsigned FRAMES_AMOUNT    = 3,
    parameter int unsigned FRAME_SIZE_BYTES = 4147200,
    parameter int unsigned ADDR_WIDTH       = 32,
    parameter int unsigned MODE             = 0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         wr_req_i,
    output logic                         wr_grant_o,
    output logic                         wr_skip_o,
    output logic [ADDR_WIDTH-1:0]        wr_addr_o,
    input  logic                         wr_done_i,
    input  logic                         wr_drop_i,
    input  logic                         rd_req_i,
    output logic                         rd_grant_o,
    output logic                         rd_repeat_o,
    output logic [ADDR_WIDTH-1:0]        rd_addr_o,
    input  logic                         rd_done_i,
    output logic [15:0]                  dropped_o,
    output logic [31:0]                  frames_wr_o,
    output logic [31:0]                  frames_rd_o,
    output logic [3*FRAMES_AMOUNT-1:0]   slot_state_o
);

    localparam int unsigned IDX_W = $clog2(FRAMES_AMOUNT);
    localparam int unsigned CNT_W = $clog2(FRAMES_AMOUNT + 1);
    localparam logic [63:0] END_ADDR = 64'(START_ADDR) + 64'(FRAMES_AMOUNT) * 64'(FRAME_SIZE_BYTES);

    if (FRAMES_AMOUNT < 3) begin : g_bad_frames
        $error("frame_slot_mgr: FRAMES_AMOUNT must be at least 3");
    end
    if (ADDR_WIDTH < 64 && END_ADDR > (64'd1 << ADDR_WIDTH)) begin : g_bad_range
        $error("frame_slot_mgr: slot range does not fit in ADDR_WIDTH");
    end

    typedef enum logic [2:0] {
        S_FREE    = 3'd0,
        S_WRITING = 3'd1,
        S_READY   = 3'd2,
        S_READING = 3'd3,
        S_LAST    = 3'd4
    } slot_state_t;

    typedef logic [IDX_W-1:0] idx_t;

    function automatic logic [ADDR_WIDTH-1:0] slot_addr(input idx_t idx);
        return ADDR_WIDTH'(START_ADDR) + ADDR_WIDTH'(idx) * ADDR_WIDTH'(FRAME_SIZE_BYTES);
    endfunction

    // Handshake: *_req_i/*_done_i/wr_drop_i are single-cycle strobes; a request is
    // latched as pending and answered by exactly one *_grant_o pulse (at least one
    // cycle later) whose address and flag outputs are valid in that same cycle.
    slot_state_t slot_q [FRAMES_AMOUNT];
    slot_state_t slot_n [FRAMES_AMOUNT];
    idx_t        rdq_q  [FRAMES_AMOUNT];
    idx_t        rdq_n  [FRAMES_AMOUNT];
    logic [CNT_W-1:0] rdq_cnt_q, rdq_cnt_n;

    logic                  wr_pend_q, wr_pend_n;
    logic                  rd_pend_q, rd_pend_n;
    logic                  wr_grant_n, wr_skip_n, rd_grant_n, rd_repeat_n;
    logic [ADDR_WIDTH-1:0] wr_addr_n, rd_addr_n;
    logic [15:0]           dropped_n;
    logic [16:0]           drop_sum;
    logic [7:0]            drop_inc;

    logic wr_busy, commit, wr_owned, rd_owned;
    logic rdy_found, last_found, free_found;
    idx_t wr_sel, rdy_sel, last_sel, free_sel;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_q      <= '{default: S_FREE};
            rdq_q       <= '{default: '0};
            rdq_cnt_q   <= '0;
            wr_pend_q   <= 1'b0;
            rd_pend_q   <= 1'b0;
            wr_grant_o  <= 1'b0;
            wr_skip_o   <= 1'b0;
            wr_addr_o   <= '0;
            rd_grant_o  <= 1'b0;
            rd_repeat_o <= 1'b0;
            rd_addr_o   <= '0;
            dropped_o   <= '0;
        end else begin
            slot_q      <= slot_n;
            rdq_q       <= rdq_n;
            rdq_cnt_q   <= rdq_cnt_n;
            wr_pend_q   <= wr_pend_n;
            rd_pend_q   <= rd_pend_n;
            wr_grant_o  <= wr_grant_n;
            wr_skip_o   <= wr_skip_n;
            wr_addr_o   <= wr_addr_n;
            rd_grant_o  <= rd_grant_n;
            rd_repeat_o <= rd_repeat_n;
            rd_addr_o   <= rd_addr_n;
            dropped_o   <= dropped_n;
        end
    end

    // One cycle is evaluated in order: commit/drop, rd_done, read grant, write grant.
    always_comb begin
        slot_n      = slot_q;
        rdq_n       = rdq_q;
        rdq_cnt_n   = rdq_cnt_q;
        wr_pend_n   = wr_pend_q;
        rd_pend_n   = rd_pend_q;
        wr_grant_n  = 1'b0;
        wr_skip_n   = 1'b0;
        wr_addr_n   = wr_addr_o;
        rd_grant_n  = 1'b0;
        rd_repeat_n = 1'b0;
        rd_addr_n   = rd_addr_o;
        drop_inc    = '0;
        wr_busy     = 1'b0;
        wr_sel      = '0;
        commit      = 1'b0;
        wr_owned    = 1'b0;
        rd_owned    = 1'b0;
        rdy_found   = 1'b0;
        rdy_sel     = '0;
        last_found  = 1'b0;
        last_sel    = '0;
        free_found  = 1'b0;
        free_sel    = '0;

        for (int i = 0; i < FRAMES_AMOUNT; i++) begin
            if (slot_q[i] == S_WRITING) begin
                wr_busy = 1'b1;
                wr_sel  = IDX_W'(i);
            end
        end

        if (wr_busy && wr_drop_i) begin
            slot_n[wr_sel] = S_FREE;
            drop_inc       = drop_inc + 8'd1;
        end else if (wr_busy && wr_done_i) begin
            commit = 1'b1;
            if (MODE == 0) begin
                // Newest frame supersedes any committed frame nobody has picked up.
                for (int i = 0; i < FRAMES_AMOUNT; i++) begin
                    if (slot_n[i] == S_READY) begin
                        slot_n[i] = S_FREE;
                        drop_inc  = drop_inc + 8'd1;
                    end
                end
            end else begin
                rdq_n[IDX_W'(rdq_cnt_n)] = wr_sel;
                rdq_cnt_n                = rdq_cnt_n + CNT_W'(1);
            end
            slot_n[wr_sel] = S_READY;
        end

        if (rd_done_i) begin
            for (int i = 0; i < FRAMES_AMOUNT; i++) begin
                if (slot_n[i] == S_READING) slot_n[i] = S_LAST;
            end
        end

        for (int i = 0; i < FRAMES_AMOUNT; i++) begin
            if (slot_n[i] == S_WRITING) wr_owned = 1'b1;
            if (slot_n[i] == S_READING) rd_owned = 1'b1;
        end
        if (wr_req_i && !wr_owned) wr_pend_n = 1'b1;
        if (rd_req_i && !rd_owned) rd_pend_n = 1'b1;

        if (MODE == 0) begin
            for (int i = 0; i < FRAMES_AMOUNT; i++) begin
                if (slot_n[i] == S_READY) begin
                    rdy_found = 1'b1;
                    rdy_sel   = IDX_W'(i);
                end
            end
        end else begin
            rdy_found = (rdq_cnt_n != '0);
            rdy_sel   = rdq_n[0];
        end
        for (int i = 0; i < FRAMES_AMOUNT; i++) begin
            if (slot_n[i] == S_LAST) begin
                last_found = 1'b1;
                last_sel   = IDX_W'(i);
            end
        end

        if (rd_pend_n) begin
            if (rdy_found) begin
                for (int i = 0; i < FRAMES_AMOUNT; i++) begin
                    if (slot_n[i] == S_LAST) slot_n[i] = S_FREE;
                end
                slot_n[rdy_sel] = S_READING;
                if (MODE != 0) begin
                    for (int i = 0; i < FRAMES_AMOUNT - 1; i++) rdq_n[i] = rdq_n[i+1];
                    rdq_cnt_n = rdq_cnt_n - CNT_W'(1);
                end
                rd_grant_n = 1'b1;
                rd_addr_n  = slot_addr(rdy_sel);
                rd_pend_n  = 1'b0;
            end else if (last_found) begin
                slot_n[last_sel] = S_READING;
                rd_grant_n       = 1'b1;
                rd_repeat_n      = 1'b1;
                rd_addr_n        = slot_addr(last_sel);
                rd_pend_n        = 1'b0;
            end
        end

        for (int i = 0; i < FRAMES_AMOUNT; i++) begin
            if (!free_found && slot_n[i] == S_FREE) begin
                free_found = 1'b1;
                free_sel   = IDX_W'(i);
            end
        end

        if (wr_pend_n) begin
            wr_grant_n = 1'b1;
            wr_pend_n  = 1'b0;
            if (free_found) begin
                slot_n[free_sel] = S_WRITING;
                wr_addr_n        = slot_addr(free_sel);
            end else begin
                // FIFO full: the writer throws this frame away, address stays put.
                wr_skip_n = 1'b1;
                drop_inc  = drop_inc + 8'd1;
            end
        end

        drop_sum  = 17'(dropped_o) + 17'(drop_inc);
        dropped_n = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    for (genvar g = 0; g < FRAMES_AMOUNT; g++) begin : g_dbg
        assign slot_state_o[3*g +: 3] = slot_q[g];
    end

`ifdef FRAME_SLOT_MGR_STATS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frames_wr_o <= '0;
            frames_rd_o <= '0;
        end else begin
            if (commit && frames_wr_o != '1) frames_wr_o <= frames_wr_o + 32'd1;
            if (rd_grant_n && !rd_repeat_n && frames_rd_o != '1) frames_rd_o <= frames_rd_o + 32'd1;
        end
    end
`else
    assign frames_wr_o = '0;
    assign frames_rd_o = '0;
`endif

endmodule

// File: tb/tb_frame_slot_mgr.sv
// Directed bench for frame_slot_mgr: a LATEST instance (3 slots at 0x1000_0000) and a FIFO instance (4 slots at 0).
module tb_frame_slot_mgr;

    localparam logic [4:0] WRQ = 5'b10000;
    localparam logic [4:0] WDN = 5'b01000;
    localparam logic [4:0] WDP = 5'b00100;
    localparam logic [4:0] RRQ = 5'b00010;
    localparam logic [4:0] RDN = 5'b00001;

    localparam logic [31:0] L0 = 32'h1000_0000;
    localparam logic [31:0] L1 = 32'h103F_4800;
    localparam logic [31:0] L2 = 32'h107E_9000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wr_req = 1'b0, wr_done = 1'b0, wr_drop = 1'b0, rd_req = 1'b0, rd_done = 1'b0;

    logic        l_wr_grant, l_wr_skip, l_rd_grant, l_rd_repeat;
    logic [31:0] l_wr_addr, l_rd_addr, l_frames_wr, l_frames_rd;
    logic [15:0] l_dropped;
    logic [8:0]  l_slots;
    logic        f_wr_grant, f_wr_skip, f_rd_grant, f_rd_repeat;
    logic [31:0] f_wr_addr, f_rd_addr, f_frames_wr, f_frames_rd;
    logic [15:0] f_dropped;
    logic [11:0] f_slots;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_f [4] = '{32'h0000_0000, 32'h003F_4800, 32'h007E_9000, 32'h00BD_D800};

    always #5 clk = ~clk;

    frame_slot_mgr #(.START_ADDR(32'h1000_0000), .FRAMES_AMOUNT(3), .FRAME_SIZE_BYTES(4147200),
                     .ADDR_WIDTH(32), .MODE(0)) dut_l (
        .clk_i(clk), .rst_i(rst),
        .wr_req_i(wr_req), .wr_grant_o(l_wr_grant), .wr_skip_o(l_wr_skip), .wr_addr_o(l_wr_addr),
        .wr_done_i(wr_done), .wr_drop_i(wr_drop),
        .rd_req_i(rd_req), .rd_grant_o(l_rd_grant), .rd_repeat_o(l_rd_repeat), .rd_addr_o(l_rd_addr),
        .rd_done_i(rd_done), .dropped_o(l_dropped), .frames_wr_o(l_frames_wr), .frames_rd_o(l_frames_rd),
        .slot_state_o(l_slots)
    );

    frame_slot_mgr #(.START_ADDR(0), .FRAMES_AMOUNT(4), .FRAME_SIZE_BYTES(4147200),
                     .ADDR_WIDTH(32), .MODE(1)) dut_f (
        .clk_i(clk), .rst_i(rst),
        .wr_req_i(wr_req), .wr_grant_o(f_wr_grant), .wr_skip_o(f_wr_skip), .wr_addr_o(f_wr_addr),
        .wr_done_i(wr_done), .wr_drop_i(wr_drop),
        .rd_req_i(rd_req), .rd_grant_o(f_rd_grant), .rd_repeat_o(f_rd_repeat), .rd_addr_o(f_rd_addr),
        .rd_done_i(rd_done), .dropped_o(f_dropped), .frames_wr_o(f_frames_wr), .frames_rd_o(f_frames_rd),
        .slot_state_o(f_slots)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Strobes the selected inputs for one cycle; outputs registered at that edge are visible on return.
    task automatic drive(input logic [4:0] v);
        {wr_req, wr_done, wr_drop, rd_req, rd_done} = v;
        step();
        {wr_req, wr_done, wr_drop, rd_req, rd_done} = '0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if ({l_wr_grant, l_wr_skip, l_rd_grant, l_rd_repeat} !== 4'b0) begin n_bad++; $display("FAIL reset_l_flags: got %b want 0000", {l_wr_grant, l_wr_skip, l_rd_grant, l_rd_repeat}); end
        n_cmp++; if ({f_wr_grant, f_wr_skip, f_rd_grant, f_rd_repeat} !== 4'b0) begin n_bad++; $display("FAIL reset_f_flags: got %b want 0000", {f_wr_grant, f_wr_skip, f_rd_grant, f_rd_repeat}); end
        n_cmp++; if (l_wr_addr !== 32'h0) begin n_bad++; $display("FAIL reset_l_wr_addr: got %h want 0", l_wr_addr); end
        n_cmp++; if (l_rd_addr !== 32'h0) begin n_bad++; $display("FAIL reset_l_rd_addr: got %h want 0", l_rd_addr); end
        n_cmp++; if (l_dropped !== 16'h0) begin n_bad++; $display("FAIL reset_l_dropped: got %0d want 0", l_dropped); end
        n_cmp++; if ({f_wr_addr, f_rd_addr, f_dropped} !== 80'h0) begin n_bad++; $display("FAIL reset_f_vals: got %h/%h/%0d want 0", f_wr_addr, f_rd_addr, f_dropped); end
        n_cmp++; if ({l_frames_wr, l_frames_rd, f_frames_wr, f_frames_rd} !== 128'h0) begin n_bad++; $display("FAIL reset_stats: got nonzero frame counters"); end
    endtask

    task automatic test_read_before_commit();
        int grants;
        do_reset();
        grants = 0;
        drive(RRQ);
        if (f_rd_grant) grants++;
        for (int i = 0; i < 100; i++) begin
            step();
            if (f_rd_grant) grants++;
        end
        n_cmp++; if (grants !== 0) begin n_bad++; $display("FAIL early_rd_grant: got %0d grants want 0", grants); end
        drive(WRQ);
        n_cmp++; if ({f_wr_grant, f_wr_skip} !== 2'b10) begin n_bad++; $display("FAIL first_wr_grant: got grant/skip %b want 10", {f_wr_grant, f_wr_skip}); end
        n_cmp++; if (f_wr_addr !== 32'h0) begin n_bad++; $display("FAIL first_wr_addr: got %h want 0", f_wr_addr); end
        drive(WDN);
        n_cmp++; if ({f_rd_grant, f_rd_repeat} !== 2'b10) begin n_bad++; $display("FAIL pending_rd_grant: got grant/repeat %b want 10", {f_rd_grant, f_rd_repeat}); end
        n_cmp++; if (f_rd_addr !== 32'h0) begin n_bad++; $display("FAIL pending_rd_addr: got %h want 0", f_rd_addr); end
        step();
        n_cmp++; if (f_rd_grant !== 1'b0) begin n_bad++; $display("FAIL rd_grant_pulse: got %b want 0", f_rd_grant); end
    endtask

    task automatic test_latest_addrs();
        do_reset();
        drive(WRQ);
        n_cmp++; if (l_wr_addr !== L0) begin n_bad++; $display("FAIL latest_addr0: got %h want %h", l_wr_addr, L0); end
        drive(WDN);
        drive(RRQ);
        n_cmp++; if ({l_rd_grant, l_rd_addr} !== {1'b1, L0}) begin n_bad++; $display("FAIL latest_rd0: got %b %h want 1 %h", l_rd_grant, l_rd_addr, L0); end
        drive(WRQ);
        n_cmp++; if (l_wr_addr !== L1) begin n_bad++; $display("FAIL latest_addr1: got %h want %h", l_wr_addr, L1); end
        drive(WDN);
        drive(WRQ);
        n_cmp++; if (l_wr_addr !== L2) begin n_bad++; $display("FAIL latest_addr2: got %h want %h", l_wr_addr, L2); end
        n_cmp++; if (l_dropped !== 16'd0) begin n_bad++; $display("FAIL latest_no_drop: got %0d want 0", l_dropped); end
    endtask

    task automatic test_latest_drop_repeat();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(WRQ);
            n_cmp++; if (l_wr_addr !== ((k == 1) ? L1 : L0)) begin n_bad++; $display("FAIL recycle_addr%0d: got %h want %h", k, l_wr_addr, (k == 1) ? L1 : L0); end
            drive(WDN);
        end
        n_cmp++; if (l_dropped !== 16'd2) begin n_bad++; $display("FAIL latest_dropped: got %0d want 2", l_dropped); end
        drive(RRQ);
        n_cmp++; if ({l_rd_grant, l_rd_repeat, l_rd_addr} !== {2'b10, L0}) begin n_bad++; $display("FAIL newest_rd: got %b%b %h want 10 %h", l_rd_grant, l_rd_repeat, l_rd_addr, L0); end
        drive(RDN);
        drive(RRQ);
        n_cmp++; if ({l_rd_grant, l_rd_repeat, l_rd_addr} !== {2'b11, L0}) begin n_bad++; $display("FAIL repeat_rd: got %b%b %h want 11 %h", l_rd_grant, l_rd_repeat, l_rd_addr, L0); end
        drive(RDN);
        drive(WRQ);
        n_cmp++; if (l_wr_addr !== L1) begin n_bad++; $display("FAIL wr_past_last: got %h want %h", l_wr_addr, L1); end
        drive(WDN);
        drive(RRQ);
        n_cmp++; if ({l_rd_grant, l_rd_repeat, l_rd_addr} !== {2'b10, L1}) begin n_bad++; $display("FAIL fresh_rd: got %b%b %h want 10 %h", l_rd_grant, l_rd_repeat, l_rd_addr, L1); end
    endtask

    task automatic test_fifo();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(WRQ);
            n_cmp++; if (f_wr_addr !== exp_f[k]) begin n_bad++; $display("FAIL fifo_wr_addr%0d: got %h want %h", k, f_wr_addr, exp_f[k]); end
            drive(WDN);
        end
        drive(WRQ);
        n_cmp++; if ({f_wr_grant, f_wr_skip} !== 2'b11) begin n_bad++; $display("FAIL fifo_skip: got grant/skip %b want 11", {f_wr_grant, f_wr_skip}); end
        n_cmp++; if (f_wr_addr !== exp_f[3]) begin n_bad++; $display("FAIL fifo_skip_addr: got %h want %h", f_wr_addr, exp_f[3]); end
        n_cmp++; if (f_dropped !== 16'd1) begin n_bad++; $display("FAIL fifo_dropped: got %0d want 1", f_dropped); end
        for (int k = 0; k < 3; k++) begin
            drive(RRQ);
            n_cmp++; if ({f_rd_grant, f_rd_repeat, f_rd_addr} !== {2'b10, exp_f[k]}) begin n_bad++; $display("FAIL fifo_rd%0d: got %b%b %h want 10 %h", k, f_rd_grant, f_rd_repeat, f_rd_addr, exp_f[k]); end
            drive(RDN);
        end
`ifdef FRAME_SLOT_MGR_STATS_EN
        n_cmp++; if ({f_frames_wr, f_frames_rd} !== {32'd4, 32'd3}) begin n_bad++; $display("FAIL fifo_stats: got %0d/%0d want 4/3", f_frames_wr, f_frames_rd); end
`else
        n_cmp++; if ({f_frames_wr, f_frames_rd} !== 64'd0) begin n_bad++; $display("FAIL fifo_stats: got %0d/%0d want 0/0", f_frames_wr, f_frames_rd); end
`endif
    endtask

    task automatic test_same_cycle();
        do_reset();
        drive(WRQ);
        drive(WDN | RRQ);
        n_cmp++; if ({l_rd_grant, l_rd_repeat, l_rd_addr} !== {2'b10, L0}) begin n_bad++; $display("FAIL commit_and_req: got %b%b %h want 10 %h", l_rd_grant, l_rd_repeat, l_rd_addr, L0); end
        drive(WRQ);
        n_cmp++; if (l_wr_addr !== L1) begin n_bad++; $display("FAIL wr_beside_reader: got %h want %h", l_wr_addr, L1); end
        drive(WDN | WDP);
        n_cmp++; if (l_dropped !== 16'd1) begin n_bad++; $display("FAIL done_drop_count: got %0d want 1", l_dropped); end
        n_cmp++; if (l_rd_grant !== 1'b0) begin n_bad++; $display("FAIL done_drop_no_rd: got %b want 0", l_rd_grant); end
        drive(WRQ);
        n_cmp++; if (l_wr_addr !== L1) begin n_bad++; $display("FAIL dropped_slot_free: got %h want %h", l_wr_addr, L1); end
    endtask

    // Entered with slot 0 READING and slot 1 WRITING on the LATEST instance.
    task automatic test_reset_mid_frame();
        rst = 1'b1;
        step();
        n_cmp++; if ({l_wr_grant, l_wr_skip, l_rd_grant, l_rd_repeat} !== 4'b0) begin n_bad++; $display("FAIL midrst_flags: got %b want 0000", {l_wr_grant, l_wr_skip, l_rd_grant, l_rd_repeat}); end
        n_cmp++; if ({l_wr_addr, l_rd_addr, l_dropped} !== 80'h0) begin n_bad++; $display("FAIL midrst_vals: got %h/%h/%0d want 0", l_wr_addr, l_rd_addr, l_dropped); end
        rst = 1'b0;
        drive(WRQ);
        n_cmp++; if ({l_wr_grant, l_wr_addr} !== {1'b1, L0}) begin n_bad++; $display("FAIL midrst_regrant: got %b %h want 1 %h", l_wr_grant, l_wr_addr, L0); end
    endtask

    initial begin
        test_reset();
        test_read_before_commit();
        test_latest_addrs();
        test_latest_drop_repeat();
        test_fifo();
        test_same_cycle();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
